alu_result_stage: RTL and testbench

//  Registered, flow-controlled successor to the ALU combinational result mux. Selects one of
//  NUM_OPS operation results by op code and computes N/Z/C/V status flags. Buffers result+flags
//  in a 2-entry skid buffer with valid/ready on both sides. Sits between ALU function units and

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_result_stage_if.sv | 44 ++++
 rtl/alu_result_stage_skid.sv | 79 +++++++
 rtl/alu_result_stage.sv | 71 +++++++
 tb/tb_alu_result_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the ALU result stage.
//                - alu_op_e    : operation codes; the result mux index is the
//                                op code.
//                - alu_flags_t : status flags {n,z,c,v}, with n in the MSB.
//                - ALU_FLAG_W  : packed width of alu_flags_t.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam int ALU_OP_W   = 4;
   localparam int ALU_FLAG_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_NOT = 4'd4,
      ALU_XOR = 4'd5,
      ALU_LSL = 4'd6,
      ALU_ASL = 4'd7,
      ALU_LSR = 4'd8,
      ALU_ASR = 4'd9,
      ALU_F10 = 4'd10,
      ALU_F11 = 4'd11,
      ALU_F12 = 4'd12,
      ALU_F13 = 4'd13,
      ALU_F14 = 4'd14,
      ALU_F15 = 4'd15
   } alu_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage_if
//  Description : Bundles the upstream and downstream handshake/data signals
//                of the ALU result stage.
//                Upstream  : op_results_i, op_i, carry_i, ovf_i, valid_i, ready_o
//                Downstream: result_o, flags_o, valid_o, ready_i
//                Modports:
//                - slave  : the stage itself
//                - master : the environment that drives the stage (the ALU
//                           units upstream plus the writeback consumer)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_result_stage_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_OPS = 16
) ();
   import alu_pkg::*;

   localparam int OP_W = $clog2(NUM_OPS);

   logic [NUM_OPS-1:0][WIDTH-1:0] op_results_i;
   logic [OP_W-1:0]               op_i;
   logic                          carry_i;
   logic                          ovf_i;
   logic                          valid_i;
   logic                          ready_o;
   logic [WIDTH-1:0]              result_o;
   logic [ALU_FLAG_W-1:0]         flags_o;
   logic                          valid_o;
   logic                          ready_i;

   modport slave (
      input  op_results_i, op_i, carry_i, ovf_i, valid_i, ready_i,
      output ready_o, result_o, flags_o, valid_o
   );

   modport master (
      output op_results_i, op_i, carry_i, ovf_i, valid_i, ready_i,
      input  ready_o, result_o, flags_o, valid_o
   );

endinterface
`default_nettype wire

// File: rtl/alu_result_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : alu_skid_buffer
//  Description : Two-entry skid buffer with valid/ready on both sides.
//                It holds an output register (OUT) and a skid register (SKID).
//                ready_o is decoded from the state register only, so it never
//                depends combinationally on ready_i. It reaches full
//                throughput of one transfer per cycle.
//  Ports       : clk_i, rst_i         clock, sync active-high reset
//                valid_i/ready_o/data_i  upstream handshake + payload
//                valid_o/ready_i/data_o  downstream handshake + payload
//  Revision    : 1.0  initial release
// ============================================================================
module alu_skid_buffer #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o
);

   // Occupancy states
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_out;
   logic [DATA_W-1:0] r_skid;
   logic              w_accept;

   assign w_accept = valid_i && ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_EMPTY;
         r_out   <= '0;
         r_skid  <= '0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_out   <= data_i;
                  r_state <= S_ONE;
               end
            end
            S_ONE: begin
               if (w_accept && ready_i) begin
                  r_out <= data_i;
               end else if (w_accept) begin
                  // Downstream stalled: park the new entry behind OUT
                  r_skid  <= data_i;
                  r_state <= S_FULL;
               end else if (ready_i) begin
                  r_state <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (ready_i) begin
                  r_out   <= r_skid;
                  r_state <= S_ONE;
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

   assign valid_o = (r_state != S_EMPTY);
   assign ready_o = (r_state != S_FULL);
   assign data_o  = r_out;

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage
//  Description : Registered, flow-controlled ALU result mux. It selects one of
//                NUM_OPS results by op code, computes the N/Z/C/V flags, and
//                buffers {result, flags} in a two-entry skid buffer.
//  Ports       : clk_i, rst_i  clock, sync active-high reset
//                bus (slave)   upstream op results/op/carry/ovf with
//                              valid/ready, and downstream result/flags with
//                              valid/ready
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int NUM_OPS = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   alu_result_stage_if.slave   bus
);

   localparam int OP_W   = $clog2(NUM_OPS);
   localparam int DATA_W = WIDTH + ALU_FLAG_W;

   logic [WIDTH-1:0]  w_sel;
   alu_flags_t        w_flags;
   logic              w_is_arith;
   logic [DATA_W-1:0] w_in_data;
   logic [DATA_W-1:0] w_out_data;

   // Op codes beyond NUM_OPS exist only when NUM_OPS is not a power of 2.
   // They select zero.
   always_comb begin
      w_sel = '0;
      if (int'(bus.op_i) < NUM_OPS) begin
         w_sel = bus.op_results_i[bus.op_i];
      end
   end

   // Carry/overflow have meaning only for the adder ops.
   assign w_is_arith = (bus.op_i == OP_W'(ALU_ADD)) || (bus.op_i == OP_W'(ALU_SUB));

   always_comb begin
      w_flags.n = w_sel[WIDTH-1];
      w_flags.z = (w_sel == '0);
      w_flags.c = w_is_arith ? bus.carry_i : 1'b0;
      w_flags.v = w_is_arith ? bus.ovf_i   : 1'b0;
   end

   assign w_in_data = {w_sel, w_flags};

   alu_skid_buffer #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (bus.valid_i),
      .ready_o (bus.ready_o),
      .data_i  (w_in_data),
      .valid_o (bus.valid_o),
      .ready_i (bus.ready_i),
      .data_o  (w_out_data)
   );

   assign bus.result_o = w_out_data[DATA_W-1 -: WIDTH];
   assign bus.flags_o  = w_out_data[ALU_FLAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_stage
//  Description : Self-checking bench for alu_result_stage (WIDTH=8,
//                NUM_OPS=16). A queue-based reference model predicts the
//                outputs: each accepted input pushes its expected
//                {result, flags}, and each downstream transfer pops one.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_result_stage;

   localparam int WIDTH   = 8;
   localparam int NUM_OPS = 16;

   logic clk;
   logic rst;

   int n_chk;
   int n_err;
   int n_acc;

   logic [11:0] q[$];

   alu_result_stage_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) bus ();

   alu_result_stage #(
      .WIDTH   (WIDTH),
      .NUM_OPS (NUM_OPS)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected {result[7:0], n, z, c, v} for one input set
   function automatic logic [11:0] expect_of(input logic [15:0][7:0] res, input logic [3:0] op,
                                             input logic carry, input logic ovf);
      logic [7:0] r;
      logic       n, z, c, v;
      r = res[op];
      n = (r >= 8'd128);
      z = (r == 8'd0);
      c = (op == 4'd0 || op == 4'd1) ? carry : 1'b0;
      v = (op == 4'd0 || op == 4'd1) ? ovf   : 1'b0;
      return {r, n, z, c, v};
   endfunction

   // Called at the negedge: compare the current outputs, then advance the model
   // by the handshakes that will happen at the coming posedge.
   task automatic model_step();
      int sz;
      sz = q.size();
      check("valid_o", 32'(bus.valid_o), 32'(sz > 0));
      check("ready_o", 32'(bus.ready_o), 32'(sz < 2));
      if (sz > 0 && bus.valid_o === 1'b1) begin
         check("result_o", 32'(bus.result_o), 32'(q[0][11:4]));
         check("flags_o",  32'(bus.flags_o),  32'(q[0][3:0]));
      end
      if (rst) begin
         q.delete();
      end else begin
         if (sz > 0 && bus.ready_i) void'(q.pop_front());
         if (bus.valid_i && sz < 2) begin
            q.push_back(expect_of(bus.op_results_i, bus.op_i, bus.carry_i, bus.ovf_i));
            n_acc++;
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      for (int k = 0; k < NUM_OPS; k++) begin
         bus.op_results_i[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      bus.op_i    = 4'($urandom_range(0, 15));
      bus.carry_i = 1'($urandom);
      bus.ovf_i   = 1'($urandom);
   endtask

   initial begin
      int start_acc;
      n_chk = 0;
      n_err = 0;
      n_acc = 0;

      // ---- 1: reset with valid_i high ----
      rst         = 1'b1;
      bus.ready_i = 1'b1;
      bus.valid_i = 1'b1;
      rand_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_o",  32'(bus.valid_o),  32'd0);
      check("rst_result_o", 32'(bus.result_o), 32'd0);
      check("rst_flags_o",  32'(bus.flags_o),  32'd0);
      check("rst_ready_o",  32'(bus.ready_o),  32'd1);
      rst         = 1'b0;
      bus.valid_i = 1'b0;
      q.delete();

      // ---- 2: ADD, zero result, carry set ----
      bus.op_results_i    = '1;
      bus.op_results_i[0] = 8'h00;
      bus.op_i            = 4'd0;
      bus.carry_i         = 1'b1;
      bus.ovf_i           = 1'b0;
      bus.valid_i         = 1'b1;
      bus.ready_i         = 1'b1;
      cyc();
      check("add_result", 32'(bus.result_o), 32'h00);
      check("add_flags",  32'(bus.flags_o),  32'b0110);

      // ---- 3: XOR, c/v masked ----
      bus.op_results_i[5] = 8'h80;
      bus.op_i            = 4'd5;
      bus.carry_i         = 1'b1;
      bus.ovf_i           = 1'b1;
      cyc();
      check("xor_result", 32'(bus.result_o), 32'h80);
      check("xor_flags",  32'(bus.flags_o),  32'b1000);
      bus.valid_i = 1'b0;
      cyc();

      // ---- 4: stall, two entries, third held ----
      bus.ready_i         = 1'b0;
      bus.valid_i         = 1'b1;
      bus.carry_i         = 1'b0;
      bus.ovf_i           = 1'b0;
      bus.op_results_i[2] = 8'h11;
      bus.op_i            = 4'd2;
      cyc();
      bus.op_results_i[3] = 8'h22;
      bus.op_i            = 4'd3;
      cyc();
      check("stall_ready_o", 32'(bus.ready_o), 32'd0);
      bus.op_results_i[4] = 8'h33;
      bus.op_i            = 4'd4;
      cyc();
      check("stall_hold_result", 32'(bus.result_o), 32'h11);
      check("stall_hold_ready",  32'(bus.ready_o),  32'd0);
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      cyc();
      check("stall_second", 32'(bus.result_o), 32'h22);
      check("stall_ready_back", 32'(bus.ready_o), 32'd1);
      cyc();
      check("stall_drained", 32'(bus.valid_o), 32'd0);

      // ---- 5: random streaming ----
      start_acc = n_acc;
      for (int i = 0; i < 2000 && (n_acc - start_acc) < 100; i++) begin
         rand_inputs();
         bus.valid_i = ($urandom_range(0, 9) < 7);
         bus.ready_i = 1'($urandom);
         cyc();
      end
      check("stream_accepted", 32'(n_acc - start_acc), 32'd100);
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      repeat (4) cyc();
      check("stream_empty_q", 32'(q.size()), 32'd0);

      // ---- 6: reset while full ----
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1;
      rand_inputs();
      cyc();
      rand_inputs();
      cyc();
      check("full_ready_o", 32'(bus.ready_o), 32'd0);
      rst = 1'b1;
      cyc();
      rst         = 1'b0;
      bus.valid_i = 1'b0;
      check("full_rst_valid", 32'(bus.valid_o), 32'd0);
      check("full_rst_ready", 32'(bus.ready_o), 32'd1);
      bus.ready_i = 1'b1;
      repeat (3) cyc();
      check("full_no_stale", 32'(bus.valid_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
